// File: rtl/frame_bank_arbiter_pkg.sv
// Shared types and constants for the frame-bank arbiter.
package frame_bank_pkg;

    typedef enum logic [1:0] {FREE, WRITING, READY, READING} bank_state_e;

    localparam int MODE_LATEST = 0;
    localparam int MODE_FIFO   = 1;
    localparam int MAX_BANKS   = 8;

endpackage

// File: rtl/frame_bank_arbiter_if.sv
// Frame-boundary inputs and bank-select / status outputs of the frame-bank arbiter.
interface frame_bank_arbiter_if #(
    parameter int NUM_BANKS = 3,
    parameter int BANK_W    = $clog2(NUM_BANKS),
    parameter int CNT_W     = 16
);
    logic                 rd_sync;
    logic                 wr_sync;
    logic                 freeze;
    logic [BANK_W-1:0]    rd_bank;
    logic [BANK_W-1:0]    wr_bank;
    logic [NUM_BANKS-1:0] ready_mask;
    logic [BANK_W-1:0]    ready_cnt;
    logic [CNT_W-1:0]     drop_cnt;
    logic [CNT_W-1:0]     repeat_cnt;

    modport master (
        output rd_sync, wr_sync, freeze,
        input  rd_bank, wr_bank, ready_mask, ready_cnt, drop_cnt, repeat_cnt
    );

    modport slave (
        input  rd_sync, wr_sync, freeze,
        output rd_bank, wr_bank, ready_mask, ready_cnt, drop_cnt, repeat_cnt
    );
endinterface

// File: rtl/frame_bank_arbiter_edge_sync.sv
// Two-flop synchroniser plus history flop; rise/fall decoded from the last two stages.
module bank_edge_sync (
    input  logic clk,
    input  logic rst_133,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1_q, s2_q, hist_q;

    always_ff @(posedge clk) begin
        if (rst_133) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            s1_q   <= async_in;
            s2_q   <= s1_q;
            hist_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~hist_q;
    assign fall  = ~s2_q & hist_q;
endmodule

// File: rtl/frame_bank_arbiter.sv
// N-bank frame-buffer arbiter: writer/reader bank assignment with latest-frame or FIFO queueing.
// Define BANK_STATS_EN to implement the drop/repeat statistics counters.
module frame_bank_arbiter
    import frame_bank_pkg::*;
#(
    parameter int NUM_BANKS = 3,
    parameter int BANK_W    = $clog2(NUM_BANKS),
    parameter int MODE      = 0,
    parameter int CNT_W     = 16
) (
    input logic                clk,
    input logic                rst_133,
    frame_bank_arbiter_if.slave bus
);
    localparam int DEPTH = NUM_BANKS - 2;
    localparam int NB    = (NUM_BANKS < MAX_BANKS) ? NUM_BANKS : MAX_BANKS;

    typedef logic [BANK_W-1:0] idx_t;

    logic rd_fall, wr_rise, frz_lvl;
    logic rd_lvl_unused, rd_rise_unused, wr_lvl_unused, wr_fall_unused;
    logic frz_rise_unused, frz_fall_unused;

    bank_edge_sync u_rd_sync (
        .clk     (clk),
        .rst_133 (rst_133),
        .async_in(bus.rd_sync),
        .level   (rd_lvl_unused),
        .rise    (rd_rise_unused),
        .fall    (rd_fall)
    );

    bank_edge_sync u_wr_sync (
        .clk     (clk),
        .rst_133 (rst_133),
        .async_in(bus.wr_sync),
        .level   (wr_lvl_unused),
        .rise    (wr_rise),
        .fall    (wr_fall_unused)
    );

    bank_edge_sync u_frz_sync (
        .clk     (clk),
        .rst_133 (rst_133),
        .async_in(bus.freeze),
        .level   (frz_lvl),
        .rise    (frz_rise_unused),
        .fall    (frz_fall_unused)
    );

    idx_t                 rd_q, rd_d, wr_q, wr_d, cnt_q, cnt_d;
    idx_t                 q_q [DEPTH];
    idx_t                 q_d [DEPTH];
    logic [NUM_BANKS-1:0] mask_q, mask_d;
    bank_state_e          st [NUM_BANKS];
    logic                 rd_ev, wr_ev, swap, search, drop_inc, rep_inc;

    assign rd_ev = rd_fall & ~frz_lvl;
    assign wr_ev = wr_rise;

    always_comb begin
        rd_d     = rd_q;
        wr_d     = wr_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        swap     = 1'b0;
        search   = 1'b0;
        drop_inc = 1'b0;
        rep_inc  = 1'b0;

        if (rd_ev) begin
            if (cnt_q != '0) begin
                rd_d = q_q[0];
                for (int i = 0; i < DEPTH - 1; i++) q_d[i] = q_q[i + 1];
                cnt_d = cnt_q - idx_t'(1);
            end else if (wr_ev) begin
                // Nothing queued: the reader takes the fresh frame, the writer the old read bank.
                rd_d = wr_q;
                wr_d = rd_q;
                swap = 1'b1;
            end else begin
                rep_inc = 1'b1;
            end
        end

        if (wr_ev && !swap) begin
            if (MODE == MODE_LATEST) begin
                drop_inc = (cnt_d != '0);
                cnt_d    = '0;
                search   = 1'b1;
            end else if (MODE == MODE_FIFO && cnt_d == idx_t'(DEPTH)) begin
                wr_d = q_d[0];
                for (int i = 0; i < DEPTH - 1; i++) q_d[i] = q_d[i + 1];
                cnt_d    = cnt_d - idx_t'(1);
                drop_inc = 1'b1;
            end else begin
                search = 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (idx_t'(i) == cnt_d) q_d[i] = wr_q;
            end
            cnt_d = cnt_d + idx_t'(1);
        end

        for (int b = 0; b < NB; b++) begin
            st[b] = FREE;
            if (idx_t'(b) == rd_d) st[b] = READING;
            for (int i = 0; i < DEPTH; i++) begin
                if (idx_t'(i) < cnt_d && q_d[i] == idx_t'(b)) st[b] = READY;
            end
        end

        // Descending scan leaves the lowest-index FREE bank in wr_d.
        if (search) begin
            for (int b = NB - 1; b >= 0; b--) begin
                if (st[b] == FREE) wr_d = idx_t'(b);
            end
        end

        for (int b = 0; b < NB; b++) mask_d[b] = (st[b] == READY);
    end

    always_ff @(posedge clk) begin
        if (rst_133) begin
            rd_q   <= '0;
            wr_q   <= idx_t'(1);
            cnt_q  <= '0;
            mask_q <= '0;
            for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
            q_q    <= q_d;
        end
    end

    assign bus.rd_bank    = rd_q;
    assign bus.wr_bank    = wr_q;
    assign bus.ready_cnt  = cnt_q;
    assign bus.ready_mask = mask_q;

`ifdef BANK_STATS_EN
    logic [CNT_W-1:0] drop_q, rep_q;

    always_ff @(posedge clk) begin
        if (rst_133) begin
            drop_q <= '0;
            rep_q  <= '0;
        end else begin
            if (drop_inc && drop_q != '1) drop_q <= drop_q + CNT_W'(1);
            if (rep_inc && rep_q != '1) rep_q <= rep_q + CNT_W'(1);
        end
    end

    assign bus.drop_cnt   = drop_q;
    assign bus.repeat_cnt = rep_q;
`else
    logic stats_unused;
    assign stats_unused   = drop_inc ^ rep_inc;
    assign bus.drop_cnt   = {CNT_W{1'b0}};
    assign bus.repeat_cnt = {CNT_W{1'b0}};
`endif
endmodule
